// File: rtl/control_sequencer.sv
// control_sequencer: instruction-class driven control FSM for the 8-bit CPU.
// Sequences fetch, operand fetch, execute and interrupt entry, with a
// variable-latency memory handshake guarded by a bus-timeout counter.
module control_sequencer #(
    parameter int unsigned OPERAND_BYTES = 1,
    parameter int unsigned MAX_WAIT      = 15
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [2:0] i_op_class,
    input  logic       i_needs_operand,
    input  logic       i_mem_ack,
    input  logic       i_irq,
    input  logic       i_irq_en,
    output logic [3:0] o_transfer_cmd,
    output logic       o_mem_req,
    output logic       o_inc_pc,
    output logic [1:0] o_inc_dec_sp,
    output logic       o_opnd_shift,
    output logic       o_alu_calculate,
    output logic       o_load_vec,
    output logic       o_irq_ack,
    output logic       o_next_instr,
    output logic       o_bus_err,
    output logic       o_halted
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned BYTE_W = 3;
    localparam int unsigned CLS_W  = 3;

    typedef enum logic [4:0] {
        ST_RESET, ST_BOUNDARY, ST_F_MA, ST_F_RD, ST_F_IR, ST_DECODE,
        ST_O_MA, ST_O_RD, ST_L_MA, ST_L_RD, ST_L_A, ST_S_MA, ST_S_MD,
        ST_S_WR, ST_EXE, ST_A_R, ST_IN, ST_OUT, ST_JMP, ST_DONE, ST_HALT,
        ST_IRQ_DEC, ST_IRQ_MA, ST_IRQ_MD, ST_IRQ_WR, ST_IRQ_VEC, ST_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [BYTE_W-1:0]   r_byte_cnt;
    logic [CLS_W-1:0]    r_op_class;
    logic                w_req;
    logic                w_wait_expired;

    // First state of each instruction class; NOP and HALT skip straight to their end state
    function automatic state_t class_entry(input logic [CLS_W-1:0] cls);
        state_t st;
        case (cls)
            3'd1:    st = ST_L_MA;
            3'd2:    st = ST_S_MA;
            3'd3:    st = ST_EXE;
            3'd4:    st = ST_IN;
            3'd5:    st = ST_OUT;
            3'd6:    st = ST_JMP;
            3'd7:    st = ST_HALT;
            default: st = ST_DONE;
        endcase
        return st;
    endfunction

    // States that hold a memory request open until acknowledged
    assign w_req = (r_state inside {ST_F_RD, ST_O_RD, ST_L_RD, ST_S_WR, ST_IRQ_WR});

    // Timeout fires on the cycle the un-acked wait count would reach MAX_WAIT
    assign w_wait_expired = (MAX_WAIT > 0) && w_req && !i_mem_ack &&
                            (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= ST_RESET;
        else         r_state <= w_next_state;
    end

    // Wait counter: counts un-acked request cycles, cleared whenever not waiting
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                  r_wait_cnt <= '0;
        else if (w_req && !i_mem_ack) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        else                          r_wait_cnt <= '0;
    end

    // Operand byte counter and class latch, both loaded in DECODE
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_byte_cnt <= '0;
            r_op_class <= '0;
        end else if (r_state == ST_DECODE) begin
            r_op_class <= i_op_class;
            if (i_needs_operand) r_byte_cnt <= BYTE_W'(OPERAND_BYTES);
        end else if (r_state == ST_O_RD && i_mem_ack && r_byte_cnt != '0) begin
            r_byte_cnt <= r_byte_cnt - BYTE_W'(1);
        end
    end

    // Next-state and Moore output decode (ack-qualified strobes in read states)
    always_comb begin
        w_next_state    = r_state;
        o_transfer_cmd  = 4'h0;
        o_mem_req       = w_req;
        o_inc_pc        = 1'b0;
        o_inc_dec_sp    = 2'b00;
        o_opnd_shift    = 1'b0;
        o_alu_calculate = 1'b0;
        o_load_vec      = 1'b0;
        o_irq_ack       = 1'b0;
        o_next_instr    = 1'b0;
        o_bus_err       = 1'b0;
        o_halted        = 1'b0;
        unique case (r_state)
            ST_RESET:    w_next_state = ST_BOUNDARY;
            ST_BOUNDARY: w_next_state = (i_irq && i_irq_en) ? ST_IRQ_DEC : ST_F_MA;
            ST_F_MA: begin
                o_transfer_cmd = 4'h1;
                w_next_state   = ST_F_RD;
            end
            ST_F_RD: begin
                o_transfer_cmd = 4'h2;
                if (i_mem_ack) begin
                    o_inc_pc     = 1'b1;
                    w_next_state = ST_F_IR;
                end else if (w_wait_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_F_IR: begin
                o_transfer_cmd = 4'h3;
                w_next_state   = ST_DECODE;
            end
            ST_DECODE:   w_next_state = i_needs_operand ? ST_O_MA : class_entry(i_op_class);
            ST_O_MA: begin
                o_transfer_cmd = 4'h1;
                w_next_state   = ST_O_RD;
            end
            ST_O_RD: begin
                o_transfer_cmd = 4'h2;
                if (i_mem_ack) begin
                    o_inc_pc     = 1'b1;
                    o_opnd_shift = 1'b1;
                    w_next_state = (r_byte_cnt <= BYTE_W'(1)) ? class_entry(r_op_class) : ST_O_MA;
                end else if (w_wait_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_L_MA: begin
                o_transfer_cmd = 4'h4;
                w_next_state   = ST_L_RD;
            end
            ST_L_RD: begin
                o_transfer_cmd = 4'h2;
                if (i_mem_ack)           w_next_state = ST_L_A;
                else if (w_wait_expired) w_next_state = ST_ERR;
            end
            ST_L_A: begin
                o_transfer_cmd = 4'h5;
                w_next_state   = ST_DONE;
            end
            ST_S_MA: begin
                o_transfer_cmd = 4'h4;
                w_next_state   = ST_S_MD;
            end
            ST_S_MD: begin
                o_transfer_cmd = 4'h8;
                w_next_state   = ST_S_WR;
            end
            ST_S_WR: begin
                o_transfer_cmd = 4'h9;
                if (i_mem_ack)           w_next_state = ST_DONE;
                else if (w_wait_expired) w_next_state = ST_ERR;
            end
            ST_EXE: begin
                o_alu_calculate = 1'b1;
                w_next_state    = ST_A_R;
            end
            ST_A_R: begin
                o_transfer_cmd = 4'h5;
                w_next_state   = ST_DONE;
            end
            ST_IN: begin
                o_transfer_cmd = 4'hC;
                w_next_state   = ST_DONE;
            end
            ST_OUT: begin
                o_transfer_cmd = 4'hD;
                w_next_state   = ST_DONE;
            end
            ST_JMP: begin
                o_transfer_cmd = 4'hB;
                w_next_state   = ST_DONE;
            end
            ST_DONE: begin
                o_next_instr = 1'b1;
                w_next_state = ST_BOUNDARY;
            end
            ST_HALT: begin
                o_halted = 1'b1;
                if (i_irq && i_irq_en) w_next_state = ST_IRQ_DEC;
            end
            ST_IRQ_DEC: begin
                o_inc_dec_sp = 2'b10;
                w_next_state = ST_IRQ_MA;
            end
            ST_IRQ_MA: begin
                o_transfer_cmd = 4'h7;
                w_next_state   = ST_IRQ_MD;
            end
            ST_IRQ_MD: begin
                o_transfer_cmd = 4'hF;
                w_next_state   = ST_IRQ_WR;
            end
            ST_IRQ_WR: begin
                o_transfer_cmd = 4'h9;
                if (i_mem_ack)           w_next_state = ST_IRQ_VEC;
                else if (w_wait_expired) w_next_state = ST_ERR;
            end
            ST_IRQ_VEC: begin
                o_load_vec   = 1'b1;
                o_irq_ack    = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_ERR:      o_bus_err = 1'b1;
            default:     w_next_state = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (OPERAND_BYTES=2, MAX_WAIT=4).
module tb_control_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic [2:0] i_op_class = 3'd0;
    logic       i_needs_operand = 1'b0;
    logic       i_mem_ack = 1'b0;
    logic       i_irq = 1'b0;
    logic       i_irq_en = 1'b0;
    logic [3:0] o_transfer_cmd;
    logic       o_mem_req, o_inc_pc, o_opnd_shift, o_alu_calculate;
    logic [1:0] o_inc_dec_sp;
    logic       o_load_vec, o_irq_ack, o_next_instr, o_bus_err, o_halted;
    logic [14:0] w_outs;

    always #5 i_clk = ~i_clk;

    control_sequencer #(.OPERAND_BYTES(2), .MAX_WAIT(4)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_op_class(i_op_class),
        .i_needs_operand(i_needs_operand), .i_mem_ack(i_mem_ack),
        .i_irq(i_irq), .i_irq_en(i_irq_en), .o_transfer_cmd(o_transfer_cmd),
        .o_mem_req(o_mem_req), .o_inc_pc(o_inc_pc), .o_inc_dec_sp(o_inc_dec_sp),
        .o_opnd_shift(o_opnd_shift), .o_alu_calculate(o_alu_calculate),
        .o_load_vec(o_load_vec), .o_irq_ack(o_irq_ack), .o_next_instr(o_next_instr),
        .o_bus_err(o_bus_err), .o_halted(o_halted)
    );

    // All outputs packed; bus_err is bit 1
    assign w_outs = {o_transfer_cmd, o_mem_req, o_inc_pc, o_inc_dec_sp, o_opnd_shift,
                     o_alu_calculate, o_load_vec, o_irq_ack, o_next_instr, o_bus_err, o_halted};

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model controls
    int ack_lat   = 1;
    int req_cyc   = 0;
    bit block_wr  = 1'b0;
    bit irq_on_alu = 1'b0;

    // Per-run statistics
    int cyc, first_ma, done_cyc, n_inc_pc, n_shift, n_alu, n_sp_dec;
    int n_load_vec, n_irq_ack, n_halted, sp_cyc, c7_cyc, cf_cyc, c9_cyc, vec_cyc, wr_wait;
    bit rec;
    int seq[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; first_ma = -1; done_cyc = -1; n_inc_pc = 0; n_shift = 0; n_alu = 0;
        n_sp_dec = 0; n_load_vec = 0; n_irq_ack = 0; n_halted = 0; sp_cyc = -1;
        c7_cyc = -1; cf_cyc = -1; c9_cyc = -1; vec_cyc = -1; wr_wait = 0; rec = 1'b0;
        seq.delete();
    endtask

    // One clock: drive memory ack at the falling edge, then sample outputs
    task automatic step();
        @(negedge i_clk);
        if (o_mem_req) begin
            req_cyc++;
            i_mem_ack = !(block_wr && o_transfer_cmd == 4'h9) && (req_cyc >= ack_lat);
        end else begin
            req_cyc   = 0;
            i_mem_ack = 1'b0;
        end
        #1;
        if (o_inc_pc)        n_inc_pc++;
        if (o_opnd_shift)    n_shift++;
        if (o_alu_calculate) n_alu++;
        if (o_load_vec)      n_load_vec++;
        if (o_irq_ack)       n_irq_ack++;
        if (o_halted)        n_halted++;
        if (o_inc_dec_sp == 2'b10) begin n_sp_dec++; sp_cyc = cyc; end
        if (o_transfer_cmd == 4'h7) c7_cyc = cyc;
        if (o_transfer_cmd == 4'hF) cf_cyc = cyc;
        if (o_transfer_cmd == 4'h9) c9_cyc = cyc;
        if (o_load_vec && o_irq_ack) vec_cyc = cyc;
        if (o_mem_req && !i_mem_ack && o_transfer_cmd == 4'h9) wr_wait++;
        if (o_transfer_cmd == 4'h1) begin
            rec = 1'b1;
            if (first_ma < 0) first_ma = cyc;
        end
        if (rec && (seq.size() == 0 || seq[$] != int'(o_transfer_cmd))) seq.push_back(int'(o_transfer_cmd));
        if (o_next_instr && done_cyc < 0) done_cyc = cyc;
        if (irq_on_alu && o_alu_calculate) i_irq = 1'b1;
        if (o_irq_ack) i_irq = 1'b0;
        cyc++;
    endtask

    task automatic run_until_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (done_cyc >= 0) break;
        end
        chk({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    endtask

    // Pulse reset, checking outputs are cleared while it is held
    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_rstn    = 1'b0;
        i_mem_ack = 1'b0;
        req_cyc   = 0;
        #1;
        chk({tag, "_outs_zero"}, int'(w_outs), 0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        clear_stats();
    endtask

    task automatic run_nop(input string tag);
        i_op_class = 3'd0; i_needs_operand = 1'b0; ack_lat = 1;
        run_until_done(tag, 30);
        chk({tag, "_fma_cyc"}, first_ma, 1);
        chk({tag, "_done_cyc"}, done_cyc, 5);
        chk({tag, "_inc_pc"}, n_inc_pc, 1);
    endtask

    int load_exp[12] = '{1, 2, 3, 0, 1, 2, 1, 2, 4, 2, 5, 0};
    bit found;

    initial begin
        clear_stats();
        #12;
        chk("reset_outs", int'(w_outs), 0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // NOP with zero-wait memory straight out of reset
        run_nop("nop");

        // LOAD with two operand bytes and 3-cycle ack latency
        clear_stats();
        i_op_class = 3'd1; i_needs_operand = 1'b1; ack_lat = 3;
        run_until_done("load", 60);
        chk("load_inc_pc", n_inc_pc, 3);
        chk("load_shift", n_shift, 2);
        chk("load_seq_len", seq.size(), 12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("load_seq_%0d", i), (i < seq.size()) ? seq[i] : -1, load_exp[i]);

        // STORE whose write is never acknowledged -> bus error
        clear_stats();
        i_op_class = 3'd2; i_needs_operand = 1'b0; ack_lat = 1; block_wr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_bus_err) break;
        end
        chk("store_bus_err", int'(o_bus_err), 1);
        chk("store_wait_cycles", wr_wait, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("err_hold_%0d", i), int'(w_outs), 2);
        end
        do_reset("err_reset");
        block_wr = 1'b0;
        run_nop("after_err");

        // ALU with interrupt raised mid-instruction
        clear_stats();
        i_op_class = 3'd3; i_irq_en = 1'b1; irq_on_alu = 1'b1;
        run_until_done("alu", 30);
        chk("alu_calc", n_alu, 1);
        chk("alu_no_irq_mid", n_sp_dec, 0);
        irq_on_alu = 1'b0;
        clear_stats();
        i_op_class = 3'd0;
        run_until_done("irq", 30);
        chk("irq_sp_cyc", sp_cyc, 1);
        chk("irq_cmd7_cyc", c7_cyc, 2);
        chk("irq_cmdF_cyc", cf_cyc, 3);
        chk("irq_cmd9_cyc", c9_cyc, 4);
        chk("irq_vec_cyc", vec_cyc, 5);
        chk("irq_done_cyc", done_cyc, 6);
        chk("irq_load_vec", n_load_vec, 1);
        chk("irq_ack", n_irq_ack, 1);
        chk("irq_sp_count", n_sp_dec, 1);

        // HALT ignores a masked interrupt, then leaves once enabled
        clear_stats();
        i_irq_en = 1'b0; i_op_class = 3'd7;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_halted) break;
        end
        chk("halt_reached", int'(o_halted), 1);
        i_irq = 1'b1;
        n_halted = 0;
        for (int i = 0; i < 5; i++) step();
        chk("halt_masked_hold", n_halted, 5);
        chk("halt_masked_sp", n_sp_dec, 0);
        clear_stats();
        i_op_class = 3'd0; i_irq_en = 1'b1;
        run_until_done("halt_irq", 30);
        chk("halt_irq_halted", n_halted, 0);
        chk("halt_irq_vec", n_load_vec, 1);
        chk("halt_irq_sp", n_sp_dec, 1);
        chk("halt_irq_out", int'(o_halted), 0);
        i_irq_en = 1'b0;

        // Asynchronous reset while an operand read is pending
        clear_stats();
        i_op_class = 3'd1; i_needs_operand = 1'b1; ack_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (n_inc_pc == 1 && o_mem_req && !o_inc_pc) begin found = 1'b1; break; end
        end
        chk("ord_reached", int'(found), 1);
        chk("ord_req_high", int'(o_mem_req), 1);
        i_rstn = 1'b0;
        i_mem_ack = 1'b0;
        req_cyc = 0;
        #1;
        chk("ord_async_outs", int'(w_outs), 0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        clear_stats();
        run_nop("after_ord");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised successor to the current fixed-opcode control FSM of the 8-bit CPU.
- Sequences fetch, operand fetch, execute and interrupt entry from pre-decoded instruction classes supplied by a separate decoder.
- Adds a variable-latency memory handshake with bus-timeout, multi-byte operands, HALT, and a vectored interrupt push.
- Drives the existing datapath through the same 4-bit transfer-command encoding: 0 none, 1 MA<-PC, 2 MD<-M[MA], 3 IR<-MD, 4 MA<-MD, 5 A<-MD/R, 7 MA<-SP, 8 MD<-A, 9 M[MA]<-MD, B PC<-MD, C A<-IN, D OUT<-A, F MD<-PC.

Parameters:
- OPERAND_BYTES, 1, operand bytes fetched per instruction that needs one (1..4).
- MAX_WAIT, 15, maximum cycles waiting for i_mem_ack before a bus error; 0 disables the timeout.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_op_class  input  3  decoded class: 0 NOP, 1 LOAD, 2 STORE, 3 ALU, 4 IN, 5 OUT, 6 JMP, 7 HALT.
- i_needs_operand  input  1  instruction carries an operand (sampled in DECODE).
- i_mem_ack  input  1  memory completes the current request this cycle.
- i_irq  input  1  level interrupt request.
- i_irq_en  input  1  interrupt enable.
- o_transfer_cmd  output  4  datapath transfer command.
- o_mem_req  output  1  memory access in progress; held until ack.
- o_inc_pc  output  1  PC increment strobe.
- o_inc_dec_sp  output  2  01 increment SP, 10 decrement SP, 00 hold.
- o_opnd_shift  output  1  shift MD into the datapath operand register.
- o_alu_calculate  output  1  ALU evaluate strobe.
- o_load_vec  output  1  PC <- interrupt vector.
- o_irq_ack  output  1  interrupt acknowledged.
- o_next_instr  output  1  one-cycle pulse when an instruction or interrupt entry completes.
- o_bus_err  output  1  sticky bus-timeout flag.
- o_halted  output  1  core in HALT.

Behaviour:
- Reset (asynchronous): state goes to RESET. All outputs are 0, the wait counter is 0 and o_bus_err is 0.
- Outputs are Moore: decoded from the state, plus the ack qualifier where noted.
- RESET -> BOUNDARY.
- BOUNDARY (cmd 0): if i_irq && i_irq_en -> IRQ_DEC, else -> F_MA.
- Fetch:
  - F_MA (cmd 1) -> F_RD.
  - F_RD (cmd 2, req=1) waits. On ack: o_inc_pc=1 that cycle, then -> F_IR.
  - F_IR (cmd 3) -> DECODE.
  - DECODE (cmd 0): if i_needs_operand -> O_MA and load byte counter = OPERAND_BYTES; else -> class state.
- Operand fetch:
  - O_MA (cmd 1) -> O_RD.
  - O_RD (cmd 2, req=1) waits. On ack: inc_pc=1 and opnd_shift=1; counter decrements.
  - After the ack, if the counter reaches 0 -> class state, else -> O_MA.
- Class states:
  - NOP: -> DONE.
  - LOAD: L_MA (cmd 4) -> L_RD (cmd 2, req, wait ack) -> L_A (cmd 5) -> DONE.
  - STORE: S_MA (cmd 4) -> S_MD (cmd 8) -> S_WR (cmd 9, req, wait ack) -> DONE.
  - ALU: EXE (alu_calculate=1) -> A_R (cmd 5) -> DONE.
  - IN: cmd C, then -> DONE.
  - OUT: cmd D, then -> DONE.
  - JMP: cmd B, then -> DONE.
  - HALT: -> HALT state.
- DONE (cmd 0, next_instr=1) -> BOUNDARY.
- HALT state: o_halted=1, cmd 0. Stays until i_irq && i_irq_en, then -> IRQ_DEC. An interrupt taken from HALT resumes at the vector.
- Interrupt entry:
  - IRQ_DEC (inc_dec_sp=10) -> IRQ_MA (cmd 7) -> IRQ_MD (cmd F) -> IRQ_WR (cmd 9, req, wait ack).
  - IRQ_VEC (load_vec=1, irq_ack=1) -> DONE.
  - Interrupts are never taken mid-instruction. i_irq is sampled only in BOUNDARY and HALT.
- Wait counter:
  - Clears on entry to any req state and counts each cycle with req=1 and ack=0.
  - If MAX_WAIT>0 and the count reaches MAX_WAIT without ack -> ERR. An ack in the same cycle wins.
- ERR: o_bus_err=1 and all other outputs 0. ERR is terminal; only reset leaves it.
- i_mem_ack outside a req state is ignored.
- Counter widths: $clog2(MAX_WAIT+1) for the wait counter, 3 bits for the operand-byte counter.

Test Plan:
- NOP, zero-wait memory (ack same cycle as req): from reset, F_MA at cycle 1, next_instr pulses at cycle 5, inc_pc exactly once.
- LOAD with needs_operand, OPERAND_BYTES=2, 3-cycle ack latency: two opnd_shift pulses, three inc_pc pulses total, cmd sequence 1,2,3,0,1,2,1,2,4,2,5,0.
- STORE with MAX_WAIT=4 and ack never asserted in S_WR: o_bus_err rises after 4 waiting cycles, then stays 1 with outputs 0 until i_rstn low; after reset, fetch restarts normally.
- i_irq raised mid-ALU with i_irq_en=1: the ALU completes, then IRQ_DEC (sp=10), cmds 7,F,9, then o_irq_ack and o_load_vec pulse together.
- HALT then i_irq with i_irq_en=0: core stays halted. Raise i_irq_en: interrupt entry runs and o_halted drops.
- Reset asserted during O_RD with req high: o_mem_req and all other outputs go to 0 asynchronously; after release, fetch restarts at F_MA.
